// File: rtl/n64_transmit_bit_byte.sv
// N64 single-wire serializer: one protocol symbol or one MSB-first byte.
// Build option N64_TX_CONSOLE_STOP_EN: digit 10 sends the short console stop.
module n64_transmit_bit_byte #(
    parameter int US_TICKS = 50
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       byte_trigger,
    input  logic [7:0] byte_data,
    input  logic       bit_trigger,
    input  logic [1:0] digit,
    output logic       n64d,
    output logic       transmitting
);

    localparam int PW = $clog2(4 * US_TICKS);
    typedef logic [PW-1:0] phase_t;

    localparam phase_t U1 = phase_t'(US_TICKS - 1);
    localparam phase_t U2 = phase_t'(2 * US_TICKS - 1);
    localparam phase_t U3 = phase_t'(3 * US_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH
    } state_t;

    state_t     state, state_n;
    phase_t     phase, phase_n;
    logic [6:0] shreg, shreg_n;
    logic [1:0] sym, sym_n;
    logic [2:0] left, left_n;
    logic       n64d_n, busy_n;
    phase_t     low_last, high_last;

    // Phase lengths of the symbol currently on the line, as last count index.
    always_comb begin
        low_last  = U2;
        high_last = U2;
        unique case (sym)
            2'b00: begin
                low_last  = U3;
                high_last = U1;
            end
            2'b01: begin
                low_last  = U1;
                high_last = U3;
            end
            2'b11: begin
                low_last  = U2;
                high_last = U2;
            end
            2'b10: begin
`ifdef N64_TX_CONSOLE_STOP_EN
                low_last  = U1;
`else
                low_last  = U2;
`endif
                high_last = U2;
            end
        endcase
    end

    always_comb begin
        state_n = state;
        phase_n = phase;
        shreg_n = shreg;
        sym_n   = sym;
        left_n  = left;
        n64d_n  = n64d;
        busy_n  = transmitting;
        unique case (state)
            IDLE: begin
                n64d_n = 1'b1;
                busy_n = 1'b0;
                if (byte_trigger) begin
                    shreg_n = byte_data[6:0];
                    sym_n   = {1'b0, byte_data[7]};
                    left_n  = 3'd7;
                    phase_n = '0;
                    state_n = LOW;
                    n64d_n  = 1'b0;
                    busy_n  = 1'b1;
                end else if (bit_trigger) begin
                    sym_n   = digit;
                    left_n  = 3'd0;
                    phase_n = '0;
                    state_n = LOW;
                    n64d_n  = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            LOW: begin
                if (phase == low_last) begin
                    phase_n = '0;
                    state_n = HIGH;
                    n64d_n  = 1'b1;
                end else begin
                    phase_n = phase + 1'b1;
                end
            end
            HIGH: begin
                if (phase == high_last) begin
                    phase_n = '0;
                    if (left != 3'd0) begin
                        left_n  = left - 3'd1;
                        sym_n   = {1'b0, shreg[6]};
                        shreg_n = {shreg[5:0], 1'b0};
                        state_n = LOW;
                        n64d_n  = 1'b0;
                    end else begin
                        state_n = IDLE;
                        n64d_n  = 1'b1;
                        busy_n  = 1'b0;
                    end
                end else begin
                    phase_n = phase + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                n64d_n  = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            phase        <= '0;
            shreg        <= '0;
            sym          <= '0;
            left         <= '0;
            n64d         <= 1'b1;
            transmitting <= 1'b0;
        end else begin
            state        <= state_n;
            phase        <= phase_n;
            shreg        <= shreg_n;
            sym          <= sym_n;
            left         <= left_n;
            n64d         <= n64d_n;
            transmitting <= busy_n;
        end
    end

endmodule

// File: tb/tb_n64_transmit_bit_byte.sv
// Randomized bench for n64_transmit_bit_byte against a waveform-list model.
// Honours N64_TX_CONSOLE_STOP_EN the same way the design does.
module tb_n64_transmit_bit_byte;

    localparam int US = 4;

    logic       sys_clk      = 1'b0;
    logic       sys_rst_n    = 1'b0;
    logic       byte_trigger = 1'b0;
    logic [7:0] byte_data    = 8'h00;
    logic       bit_trigger  = 1'b0;
    logic [1:0] digit        = 2'b00;
    logic       n64d;
    logic       transmitting;

    int errors = 0;
    int checks = 0;
    bit wave[$];

    n64_transmit_bit_byte #(.US_TICKS(US)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .byte_trigger(byte_trigger),
        .byte_data   (byte_data),
        .bit_trigger (bit_trigger),
        .digit       (digit),
        .n64d        (n64d),
        .transmitting(transmitting)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Symbol shape in microseconds, straight from the protocol table.
    task automatic add_sym(input logic [1:0] code);
        int lo;
        int hi;
        case (code)
            2'b00: begin lo = 3; hi = 1; end
            2'b01: begin lo = 1; hi = 3; end
            2'b11: begin lo = 2; hi = 2; end
            default: begin
`ifdef N64_TX_CONSOLE_STOP_EN
                lo = 1;
`else
                lo = 2;
`endif
                hi = 2;
            end
        endcase
        repeat (lo * US) wave.push_back(1'b0);
        repeat (hi * US) wave.push_back(1'b1);
    endtask

    task automatic build(input bit is_byte, input logic [7:0] b, input logic [1:0] d);
        wave.delete();
        if (is_byte) begin
            for (int i = 7; i >= 0; i--) add_sym({1'b0, b[i]});
        end else begin
            add_sym(d);
        end
    endtask

    // Called at #1 after an edge; returns #1 after the accepting edge.
    task automatic start(input logic bt, input logic [7:0] b,
                         input logic it, input logic [1:0] d);
        byte_trigger = bt;
        byte_data    = b;
        bit_trigger  = it;
        digit        = d;
        @(posedge sys_clk);
        #1;
        byte_trigger = 1'b0;
        bit_trigger  = 1'b0;
    endtask

    task automatic follow(input string tag, input bit noise, input bit poke20);
        for (int k = 0; k < wave.size(); k++) begin
            chk({tag, "_line"}, {31'd0, n64d}, {31'd0, wave[k]});
            chk({tag, "_busy"}, {31'd0, transmitting}, 32'd1);
            if (noise) begin
                byte_trigger = 1'($urandom);
                bit_trigger  = 1'($urandom);
                byte_data    = 8'($urandom);
                digit        = 2'($urandom);
            end
            if (poke20 && k == 20) begin
                byte_trigger = 1'b1;
                byte_data    = 8'hFF;
            end
            @(posedge sys_clk);
            #1;
            if (poke20 && k == 20) begin
                byte_trigger = 1'b0;
                byte_data    = 8'h3C;
            end
        end
        byte_trigger = 1'b0;
        bit_trigger  = 1'b0;
        chk({tag, "_end_busy"}, {31'd0, transmitting}, 32'd0);
        chk({tag, "_end_line"}, {31'd0, n64d}, 32'd1);
    endtask

    task automatic idle_cycles(input string tag, input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
            chk({tag, "_idle_busy"}, {31'd0, transmitting}, 32'd0);
            chk({tag, "_idle_line"}, {31'd0, n64d}, 32'd1);
        end
    endtask

    initial begin
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_line", {31'd0, n64d}, 32'd1);
        chk("rst_busy", {31'd0, transmitting}, 32'd0);
        sys_rst_n = 1'b1;
        idle_cycles("post_rst", 3);

        build(1'b1, 8'h80, 2'b00);
        start(1'b1, 8'h80, 1'b0, 2'b00);
        follow("b80", 1'b0, 1'b0);
        idle_cycles("b80", 2);

        build(1'b0, 8'h00, 2'b11);
        start(1'b0, 8'h00, 1'b1, 2'b11);
        follow("ctl_stop", 1'b0, 1'b0);

        build(1'b0, 8'h00, 2'b10);
        start(1'b0, 8'h00, 1'b1, 2'b10);
        follow("con_stop", 1'b0, 1'b0);

        build(1'b1, 8'hA5, 2'b00);
        start(1'b1, 8'hA5, 1'b0, 2'b00);
        follow("bA5", 1'b0, 1'b1);
        idle_cycles("bA5", 4);

        build(1'b1, 8'h69, 2'b11);
        start(1'b1, 8'h69, 1'b1, 2'b11);
        follow("both", 1'b0, 1'b0);

        // Back to back: trigger sampled on the edge after busy falls.
        build(1'b0, 8'h00, 2'b01);
        start(1'b0, 8'h00, 1'b1, 2'b01);
        follow("b2b", 1'b0, 1'b0);

        build(1'b1, 8'h5A, 2'b00);
        start(1'b1, 8'h5A, 1'b0, 2'b00);
        for (int k = 0; k < 10; k++) begin
            chk("pre_rst_line", {31'd0, n64d}, {31'd0, wave[k]});
            @(posedge sys_clk);
            #1;
        end
        sys_rst_n = 1'b0;
        @(posedge sys_clk);
        #1;
        chk("midrst_line", {31'd0, n64d}, 32'd1);
        chk("midrst_busy", {31'd0, transmitting}, 32'd0);
        sys_rst_n = 1'b1;
        idle_cycles("after_rst", 3);

        build(1'b1, 8'h00, 2'b00);
        start(1'b1, 8'h00, 1'b0, 2'b00);
        follow("b00", 1'b0, 1'b0);

        for (int t = 0; t < 20; t++) begin
            logic       bt;
            logic       it;
            logic [7:0] b;
            logic [1:0] d;
            bt = 1'($urandom);
            it = 1'($urandom);
            b  = 8'($urandom);
            d  = 2'($urandom);
            if (!bt) it = 1'b1;
            build(bt, b, d);
            start(bt, b, it, d);
            follow("rnd", 1'b1, 1'b0);
            if ($urandom_range(0, 1) == 1) idle_cycles("rnd", $urandom_range(1, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
